shift_arbiter: RTL

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/shift_arbiter.sv
// shift_arbiter: two-requester round-robin arbiter in front of a 16-bit
// logical-left barrel shifter, with a single-entry result holding stage.
// Optional feature macro: SHIFT_ARBITER_ZERO_BYPASS_EN (shamt == 0 requests
// skip the SHIFT state and complete one cycle earlier).

module barrelshifter (
    input  logic [15:0] i,
    input  logic [3:0]  s,
    output logic [15:0] o
);
    logic [15:0] st0, st1, st2;

    // Four log2 stages, stage k shifts left by 2^k when s[k] is set
    always_comb begin
        st0 = s[0] ? {i[14:0],   1'b0}  : i;
        st1 = s[1] ? {st0[13:0], 2'b00} : st0;
        st2 = s[2] ? {st1[11:0], 4'h0}  : st1;
        o   = s[3] ? {st2[7:0],  8'h00} : st2;
    end
endmodule

module shift_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_data,
    input  logic [3:0]  req0_shamt,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_data,
    input  logic [3:0]  req1_shamt,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_id,
    output logic        busy
);
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        last_grant;
    logic [15:0] op_data;
    logic [3:0]  op_shamt;
    logic        op_id;
    logic [15:0] shifted;
    logic        grant0;
    logic        grant1;
    logic        accept;
    logic [15:0] accept_data;
    logic [3:0]  accept_shamt;

    barrelshifter u_shifter (
        .i (op_data),
        .s (op_shamt),
        .o (shifted)
    );

    // Grant only in IDLE (and never while reset is asserted); on contention
    // the requester that did not win last time is granted
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && state == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
        accept       = grant0 | grant1;
        accept_data  = grant1 ? req1_data  : req0_data;
        accept_shamt = grant1 ? req1_shamt : req0_shamt;
    end

    // Next-state logic for the IDLE -> SHIFT -> DONE sequence
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef SHIFT_ARBITER_ZERO_BYPASS_EN
                    state_nxt = (accept_shamt == '0) ? DONE : SHIFT;
`else
                    state_nxt = SHIFT;
`endif
                end
            end
            SHIFT:   state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Operand capture on accept, result capture out of SHIFT (or on a bypassed accept)
    always_ff @(posedge clk) begin
        if (rst) begin
            op_data    <= '0;
            op_shamt   <= '0;
            op_id      <= 1'b0;
            last_grant <= 1'b1;
            res_data   <= '0;
            res_id     <= 1'b0;
        end else begin
            if (accept) begin
                op_data    <= accept_data;
                op_shamt   <= accept_shamt;
                op_id      <= grant1;
                last_grant <= grant1;
`ifdef SHIFT_ARBITER_ZERO_BYPASS_EN
                if (accept_shamt == '0) begin
                    res_data <= accept_data;
                    res_id   <= grant1;
                end
`endif
            end
            if (state == SHIFT) begin
                res_data <= shifted;
                res_id   <= op_id;
            end
        end
    end

    // Status and handshake outputs
    always_comb begin
        req0_ready = grant0;
        req1_ready = grant1;
        res_valid  = (state == DONE);
        busy       = (state != IDLE);
    end
endmodule
